// File: rtl/imem_line_responder.sv
// Line-organised instruction memory responder: answers 128-bit line reads after a fixed
// LATENCY, preloaded word-wise. Define MEM_WRITE_EN to add the write-back line write path.
module imem_line_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  mem_read,
  input  logic [27:0]           mem_addr,
  output logic [127:0]          mem_rdata,
  output logic                  mem_ready,
`ifdef MEM_WRITE_EN
  input  logic                  mem_write,
  input  logic [127:0]          mem_wdata,
`endif
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2+1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  busy
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         SINGLE = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_next;
  logic [3:0]              r_cnt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [127:0]            r_rdata;
  logic [127:0]            r_mem [DEPTH];

  logic                    w_start, w_access, w_acc_wr, w_line_wr, w_unused_addr_hi;
  logic [DEPTH_LOG2-1:0]   w_acc_idx, w_ld_line;
  logic [1:0]              w_ld_word;

  // Addresses alias modulo the array depth; the upper line-address bits are dropped.
  assign w_unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];

`ifdef MEM_WRITE_EN
  logic         r_is_wr;
  logic [127:0] r_wdata;
  logic [127:0] w_acc_wdata;

  // A simultaneous read stays asserted and is picked up after this write's RESP.
  assign w_start = (r_state == S_IDLE) && (mem_read || mem_write);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_is_wr <= 1'b0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_is_wr <= mem_write;
      r_wdata <= mem_wdata;
    end
  end

  assign w_acc_wr    = SINGLE ? mem_write : r_is_wr;
  assign w_acc_wdata = SINGLE ? mem_wdata : r_wdata;
`else
  assign w_start  = (r_state == S_IDLE) && mem_read;
  assign w_acc_wr = 1'b0;
`endif

  // With LATENCY=1 the access happens on the same edge that samples the request.
  assign w_access  = SINGLE ? w_start : ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_acc_idx = SINGLE ? mem_addr[DEPTH_LOG2-1:0] : r_idx;
  assign w_line_wr = w_access && w_acc_wr;
  assign w_ld_line = ld_addr[DEPTH_LOG2+1:2];
  assign w_ld_word = ld_addr[1:0];

  // NOTE: state and datapath registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = SINGLE ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_ready = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign mem_rdata = r_rdata;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= LAT_M1;
        r_idx <= mem_addr[DEPTH_LOG2-1:0];
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Reads sample the array before this edge's preload lands (read-before-write).
      if (w_access && !w_acc_wr) r_rdata <= r_mem[w_acc_idx];
    end
  end

  // NOTE: the storage array has no reset; its contents survive proc_reset_n.
  always_ff @(posedge clk) begin
    if (ld_en && !(w_line_wr && (w_ld_line == w_acc_idx)))
      r_mem[w_ld_line][{w_ld_word, 5'b0} +: 32] <= ld_data;
`ifdef MEM_WRITE_EN
    if (w_line_wr) r_mem[w_acc_idx] <= w_acc_wdata;
`endif
  end

endmodule

// File: tb/tb_imem_line_responder.sv
// Scoreboard bench for imem_line_responder: drivers push expected lines and ready cycles,
// a negedge monitor pops and compares on every mem_ready pulse.
module tb_imem_line_responder;
  localparam int DL2   = 8;
  localparam int LAT   = 4;
  localparam int LINES = 1 << DL2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mem_read = 1'b0;
  logic [27:0]    mem_addr = '0;
  logic [127:0]   mem_rdata;
  logic           mem_ready;
  logic           ld_en = 1'b0;
  logic [DL2+1:0] ld_addr = '0;
  logic [31:0]    ld_data = '0;
  logic           busy;
`ifdef MEM_WRITE_EN
  logic           mem_write = 1'b0;
  logic [127:0]   mem_wdata = '0;
`endif

  imem_line_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
`ifdef MEM_WRITE_EN
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
`endif
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           cyc;
    logic [127:0] data;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec  = 0;
  int           n_miss = 0;
  logic [127:0] ref_mem [LINES];
  logic [127:0] last_rdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: no mem_ready within cycle budget", name);
  endtask

  always @(negedge clk) begin
    if (mem_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 128'(mem_ready), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_cycle"}, 128'(cyc), 128'(mon_e.cyc));
        check({mon_e.tag, "_rdata"}, mem_rdata, mon_e.data);
      end
    end
  end

  function automatic int line_of(input logic [27:0] a);
    return int'(a) % LINES;
  endfunction

  task automatic preload(input int line, input int word, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = (DL2+2)'(line * 4 + word);
    ld_data = d;
    ref_mem[line][word*32 +: 32] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One read; optionally drop early, race a preload against the access edge,
  // hold the request across RESP (back-to-back) or scramble the address after sampling.
  task automatic do_read(input logic [27:0] addr, input string tag, input int drop_at,
                         input bit race, input int rw, input logic [31:0] rd,
                         input bit keep, input bit scramble);
    int           c, n, line, need, seen;
    bit           after_resp;
    logic [127:0] exp;
    line = line_of(addr);
    c    = cyc;
    exp  = ref_mem[line];
    sb.push_back('{c + LAT, exp, tag});
    if (keep) sb.push_back('{c + 2*LAT + 1, exp, {tag, "_b2b"}});
    need = keep ? 2 : 1;
    seen = 0;
    n    = 0;
    after_resp = 1'b0;
    mem_read = 1'b1;
    mem_addr = addr;
    while (seen < need) begin
      @(negedge clk);
      n++;
      ld_en = 1'b0;
      if (n > 4*LAT + 10) begin
        timeout(tag);
        mem_read = 1'b0;
        break;
      end
      if (scramble && n == 1) mem_addr = 28'($urandom);
      if (drop_at == n) mem_read = 1'b0;
      if (race && n == LAT - 1) begin
        ld_en   = 1'b1;
        ld_addr = (DL2+2)'(line * 4 + rw);
        ld_data = rd;
        ref_mem[line][rw*32 +: 32] = rd;
      end
      if (after_resp) begin
        check({tag, "_idle_busy"}, 128'(busy), 128'd0);
        after_resp = 1'b0;
      end else if (mem_ready) begin
        seen++;
        after_resp = 1'b1;
        if (seen == need) mem_read = 1'b0;
      end else begin
        check({tag, "_busy"}, 128'(busy), 128'd1);
      end
    end
    @(negedge clk);
    ld_en = 1'b0;
    check({tag, "_end_busy"}, 128'(busy), 128'd0);
    check({tag, "_hold"}, mem_rdata, exp);
    last_rdata = exp;
  endtask

`ifdef MEM_WRITE_EN
  // Read and write raised together: write first, then the still-held read sees the new line.
  // A preload to the same line on the write's access edge must lose to the write.
  task automatic collide(input int line, input logic [127:0] wdata);
    int c, n, seen;
    c = cyc;
    sb.push_back('{c + LAT, last_rdata, "coll_wr"});
    sb.push_back('{c + 2*LAT + 1, wdata, "coll_rd"});
    ref_mem[line] = wdata;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 28'(line);
    mem_wdata = wdata;
    seen = 0;
    n    = 0;
    while (seen < 2) begin
      @(negedge clk);
      n++;
      ld_en = 1'b0;
      if (n > 4*LAT + 10) begin
        timeout("coll");
        break;
      end
      if (n == LAT - 1) begin
        ld_en   = 1'b1;
        ld_addr = (DL2+2)'(line * 4);
        ld_data = ~wdata[31:0];
      end
      if (mem_ready) begin
        seen++;
        if (seen == 1) mem_write = 1'b0;
        else           mem_read  = 1'b0;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    ld_en = 1'b0;
    last_rdata = wdata;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, drop;
    bit  race, keep;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 128'(mem_ready), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_rdata", mem_rdata, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < 4; w++)
        preload(l, w, $urandom);

    preload(5, 0, 32'h11111111);
    preload(5, 1, 32'h22222222);
    preload(5, 2, 32'h33333333);
    preload(5, 3, 32'h44444444);
    do_read(28'd5, "basic", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    check("basic_line", last_rdata, 128'h44444444_33333333_22222222_11111111);
    do_read(28'h105, "alias", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    do_read(28'd5, "b2b", 0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
    do_read(28'd5, "drop", 2, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    do_read(28'd5, "race", 0, 1'b1, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    do_read(28'd5, "reread", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a read: outputs clear at once, no pulse, array intact.
    mem_read = 1'b1;
    mem_addr = 28'd5;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 128'(mem_ready), 128'd0);
    check("midrst_rdata", mem_rdata, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    repeat (LAT + 2) @(negedge clk);
    do_read(28'd5, "post_rst", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);

`ifdef MEM_WRITE_EN
    collide(3, {$urandom, $urandom, $urandom, $urandom});
    do_read(28'd3, "after_wr", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++)
        preload($urandom_range(0, LINES - 1), $urandom_range(0, 3), $urandom);
      drop = $urandom_range(0, LAT - 1);
      race = ($urandom_range(0, 3) == 0);
      keep = !race && (drop == 0) && ($urandom_range(0, 3) == 0);
      do_read(28'($urandom), "rand", drop, race, $urandom_range(0, 3), $urandom, keep, !keep);
    end

    repeat (LAT + 3) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Memory-side responder for the instruction caches' block-fill interface: it answers line read requests (`mem_read`/`mem_addr`) with a 128-bit line on `mem_rdata` and a one-cycle `mem_ready` pulse after a fixed, parameterised latency. It sits between the I-cache refill port and a local line-organised storage array that is filled at boot through a word-wide preload port. An optional write path lets the same block serve as the backing store for a write-back data cache.

## Interface

Parameters:

- `DEPTH_LOG2`, 8: log2 of the number of 128-bit lines stored (256 lines = 4 KiB).
- `LATENCY`, 4: cycles from the request being sampled to `mem_ready`; legal range is 1..15.

Ports:

- `clk`, input, 1: the single clock; everything is rising-edge.
- `proc_reset_n`, input, 1: asynchronous, active-low reset.
- `mem_read`, input, 1: line read request; the cache holds it high until it sees `mem_ready`.
- `mem_addr`, input, 28: line address (byte address bits [31:4]).
- `mem_rdata`, output, 128: returned line; word *k* of the line is on bits [32k+31:32k].
- `mem_ready`, output, 1: one-cycle completion pulse.
- `mem_write`, input, 1: line write request. Present only with `MEM_WRITE_EN`.
- `mem_wdata`, input, 128: line to write, same word packing as `mem_rdata`. Present only with `MEM_WRITE_EN`.
- `ld_en`, input, 1: preload write strobe.
- `ld_addr`, input, DEPTH_LOG2+2: preload word index. Bits [1:0] select the word within a line; the upper bits select the line.
- `ld_data`, input, 32: preload word.
- `busy`, output, 1: high while a transaction is in flight (state is not IDLE).

## Operation

**State machine:** IDLE, WAIT, RESP.

- **IDLE**
  - Sample `mem_read` (and `mem_write` with the macro).
  - If a request is present: latch the line index `mem_addr[DEPTH_LOG2-1:0]`, latch the op, latch `mem_wdata`, and load the counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, otherwise RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 1, read the array at the latched index into the `mem_rdata` register (for a write, perform the array write instead); next state is RESP.
  - The request inputs are ignored in WAIT.
- **RESP**
  - `mem_ready` is 1 for exactly this one cycle; next state is always IDLE.
- **LATENCY=1:** the array access happens on the IDLE→RESP edge.

**Handshake and address rules:**

- The cache drops `mem_read` combinationally in the RESP cycle. A request still high in the IDLE cycle after RESP is treated as a new transaction.
- Upper address bits above DEPTH_LOG2 are ignored, so addresses alias modulo the array depth (wrap-around).
- Changes to `mem_addr` after the request is sampled have no effect.

**Boundary conditions:**

- **Request dropped during WAIT:** the transaction still completes and `mem_ready` still pulses.
- **`mem_read` and `mem_write` both high in IDLE:** the write is serviced first. The read remains asserted and is serviced as the next transaction.
- **Preload colliding with an array read of the same line in the same cycle:** the read returns the old contents (read-before-write), and the preload word is written.
- **Preload colliding with a `mem_write` of the same line in the same cycle:** the `mem_write` data wins for the whole line.
- **Preload timing:** preload is accepted in every state and every cycle, with no stall.
- **`mem_rdata`:** holds the last returned line until the next read access updates it.

**Reset:**

- Reset asserted gives: state IDLE, counter 0, `mem_ready` 0, `mem_rdata` 0, `busy` 0.
- The storage array is not reset; its contents are retained.
- Reset asserted mid-transaction aborts the transaction, and no `mem_ready` is produced.

## Timing

- A request sampled in IDLE at cycle T produces `mem_ready` at cycle T+LATENCY. `mem_rdata` is valid from T+LATENCY.
- Back-to-back transactions: minimum period is LATENCY+1 cycles (RESP→IDLE takes one cycle).
- `busy` is high from T+1 through T+LATENCY.
- Preload writes complete at the `clk` edge where `ld_en` is sampled high.

## Configuration

- **`MEM_WRITE_EN` defined:**
  - The `mem_write`/`mem_wdata` ports exist.
  - A write transaction follows the same IDLE/WAIT/RESP timing.
  - The full 128-bit line is written at the access edge.
  - `mem_ready` pulses at T+LATENCY, and `mem_rdata` is unchanged by writes.
- **`MEM_WRITE_EN` undefined:**
  - Those ports and the write logic are absent.
  - The array is writable only through the preload port.

## Test plan

- **Basic read:** preload words 0x11111111, 0x22222222, 0x33333333, 0x44444444 into line 5; hold `mem_read`=1 with `mem_addr`=5 at T → `mem_ready` only at T+4; `mem_rdata`=0x44444444_33333333_22222222_11111111.
- **Aliasing:** `mem_addr`=0x105 with DEPTH_LOG2=8 → the same line-5 data is returned.
- **Back-to-back, early drop:** request held across RESP → next `mem_ready` at T+9. Separately, drop `mem_read` at T+2 → `mem_ready` still pulses at T+4.
- **Reset mid-flight:** assert `proc_reset_n`=0 at T+2 → `mem_ready` and `mem_rdata` read 0 immediately, no pulse is produced, and the array data survives a later read.
- **Collision (needs `MEM_WRITE_EN`):** simultaneous read and write to line 3 → the write completes first, then the read returns the written data 4+1 cycles later.
- **Preload/read race:** preload to line 5 in the same cycle as its array read → the old data is returned; a reread returns the new word.
